// File: rtl/sys_bus_master_pkg.sv
// rtl/sys_bus_master_pkg.sv - shared widths, defaults and state encodings for the bus master
//
// Purpose: single home for the master's default widths, queue depth, WAIT
// timeout limit and the 2-bit sequencer state encodings used by the RTL.
// Ports: none (package).

package sys_bus_master_pkg;

  // Default bus address width (IO select plus in-device offset) and data width.
  localparam int BUS_ADDR_WIDTH = 12;
  localparam int MEM_WIDTH      = 32;

  // Default request queue depth and maximum WAIT cycles before an error completion.
  localparam int BM_FIFO_DEPTH  = 4;
  localparam int BM_TIMEOUT     = 15;

  // Sequencer states, 2-bit binary.
  localparam logic [1:0] BM_IDLE = 2'd0;
  localparam logic [1:0] BM_ALE  = 2'd1;
  localparam logic [1:0] BM_CMD  = 2'd2;
  localparam logic [1:0] BM_WAIT = 2'd3;

endpackage

// File: rtl/sys_bus_master_if.sv
// rtl/sys_bus_master_if.sv - request, bus-controller and response signal bundle
//
// Purpose: groups the core-side request handshake, the bus-controller command
// signals and the completion response of sys_bus_master.
// Modports:
//   master - the sequencer: takes requests and bus status, drives commands and responses.
//   slave  - the environment: drives requests and bus status, observes commands and responses.

interface sys_bus_master_if
  import sys_bus_master_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_WIDTH,
  parameter int DATA_W = MEM_WIDTH
) ();

  // core-side request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // bus-controller side
  logic              ale_en;
  logic              bus_read_en;
  logic              bus_write_en;
  logic [ADDR_W-1:0] addr_input;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;
  logic              bus_ready;

  // completion response and status
  logic              rsp_valid;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, data_read, bus_ready,
    output req_ready, ale_en, bus_read_en, bus_write_en, addr_input, data_write,
    output rsp_valid, rsp_we, rsp_data, rsp_err, busy
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, data_read, bus_ready,
    input  req_ready, ale_en, bus_read_en, bus_write_en, addr_input, data_write,
    input  rsp_valid, rsp_we, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/sys_bus_master_req_fifo.sv
// rtl/sys_bus_master_req_fifo.sv - request queue of {we, addr, wdata} entries
//
// Purpose: synchronous FIFO holding pending requests. Head entry stays visible
// on dout until popped.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   push, din           - write an entry (ignored when full)
//   pop, dout           - retire the head entry (ignored when empty) / head entry
//   full, empty, count  - occupancy status

module bm_req_fifo #(
  parameter int W     = 45,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PW      = $clog2(DEPTH);
  localparam logic [PW:0]    DEPTH_C = DEPTH;
  localparam logic [PW:0]    CNT_ONE = 1;
  localparam logic [PW-1:0]  PTR_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sys_bus_master.sv
// rtl/sys_bus_master.sv - queued request sequencer driving the system bus controller
//
// Purpose: buffers core requests and runs each one through the controller's
// address-latch / command / wait-for-ready sequence, one at a time, returning
// read data or a timeout error on a single-cycle response strobe.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - sys_bus_master_if.master: request handshake, bus commands, response, busy

module sys_bus_master
  import sys_bus_master_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_WIDTH,
  parameter int DATA_W     = MEM_WIDTH,
  parameter int FIFO_DEPTH = BM_FIFO_DEPTH,
  parameter int TIMEOUT    = BM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  sys_bus_master_if.master  bus
);

  localparam int         EW      = 1 + ADDR_W + DATA_W;
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  logic [1:0]                    state;
  logic [7:0]                    wait_cnt;
  logic [7:0]                    cnt_next;
  logic                          seen_low;
  logic                          cur_we;
  logic [ADDR_W-1:0]             addr_q;
  logic [DATA_W-1:0]             wdata_q;
  logic                          ale_q;
  logic                          rd_en_q;
  logic                          wr_en_q;
  logic                          rsp_valid_q;
  logic                          rsp_we_q;
  logic [DATA_W-1:0]             rsp_data_q;
  logic                          rsp_err_q;

  logic [EW-1:0]                 fifo_dout;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          head_we;
  logic [ADDR_W-1:0]             head_addr;
  logic [DATA_W-1:0]             head_wdata;
  logic                          done;
  logic                          timed_out;
  logic                          pop;

  assign {head_we, head_addr, head_wdata} = fifo_dout;

  // A completion needs the controller to have gone busy first, so a ready
  // level left over from before the command cannot end the WAIT early.
  assign cnt_next  = wait_cnt + 8'd1;
  assign done      = (state == BM_WAIT) & bus.bus_ready & seen_low;
  assign timed_out = (state == BM_WAIT) & ~done & (cnt_next >= TMO_LIM);
  // The head entry is retired only when its transaction ends, never at launch.
  assign pop       = done | timed_out;

  bm_req_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .din   ({bus.req_we, bus.req_addr, bus.req_wdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BM_IDLE;
      wait_cnt    <= '0;
      seen_low    <= 1'b0;
      cur_we      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ale_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // Strobes and response fields are single-cycle unless re-asserted below.
      ale_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      case (state)
        BM_IDLE: begin
          if (!fifo_empty && bus.bus_ready) begin
            cur_we  <= head_we;
            addr_q  <= head_addr;
            wdata_q <= head_wdata;
            ale_q   <= 1'b1;
            state   <= BM_ALE;
          end
        end
        BM_ALE: begin
          rd_en_q <= ~cur_we;
          wr_en_q <= cur_we;
          state   <= BM_CMD;
        end
        BM_CMD: begin
          wait_cnt <= '0;
          seen_low <= 1'b0;
          state    <= BM_WAIT;
        end
        BM_WAIT: begin
          wait_cnt <= cnt_next;
          if (!bus.bus_ready) seen_low <= 1'b1;
          if (done || timed_out) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= cur_we;
            rsp_err_q   <= timed_out;
            rsp_data_q  <= (done && !cur_we) ? bus.data_read : '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            state       <= BM_IDLE;
          end
        end
        default: state <= BM_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = ~fifo_full;
  assign bus.ale_en       = ale_q;
  assign bus.bus_read_en  = rd_en_q;
  assign bus.bus_write_en = wr_en_q;
  assign bus.addr_input   = addr_q;
  assign bus.data_write   = wdata_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_we       = rsp_we_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = ~fifo_empty | (state != BM_IDLE);

endmodule

// File: tb/tb_sys_bus_master.sv
// tb/tb_sys_bus_master.sv - directed vector bench for sys_bus_master
//
// Purpose: drives requests through the sys_bus_master_if slave side against a
// small model bus controller and compares outputs with hand-computed values.
// Ports: none (top-level bench).

module tb_sys_bus_master;

  localparam int AW = 12;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  // model controller state
  logic          ready_m   = 1'b1;
  int            low_cnt   = 0;
  logic          hang      = 1'b0;
  logic          release_b = 1'b0;
  logic          use_addr_data = 1'b0;
  logic [DW-1:0] rd_val    = '0;

  vec_t vt [5];

  sys_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  sys_bus_master #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4),
    .TIMEOUT    (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Controller model: goes busy after seeing a command, stays low two negedges
  // (or indefinitely when hang is set) and returns ready.
  always @(negedge clk) begin
    if (!rst) begin
      ready_m = 1'b1;
      low_cnt = 0;
    end else if (bif.bus_read_en || bif.bus_write_en) begin
      ready_m = 1'b0;
      low_cnt = hang ? 1000 : 2;
    end else if (release_b) begin
      ready_m = 1'b1;
      low_cnt = 0;
    end else if (low_cnt > 0) begin
      low_cnt = low_cnt - 1;
      if (low_cnt == 0) ready_m = 1'b1;
    end
  end

  assign bif.bus_ready = ready_m;
  always_comb bif.data_read = use_addr_data ? {20'hC0000, bif.addr_input} : rd_val;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs reads at base+i, each held valid from push_at[i] until accepted, and
  // checks accept edges, one FIFO count point and in-order responses 5 cycles apart.
  task automatic run_seq(input string tag, input int npush, input int push_at[5],
                         input int acc_exp[5], input logic [AW-1:0] base,
                         input int cnt_c, input int cnt_exp);
    int            pushed = 0;
    int            nrsp   = 0;
    logic          rdy;
    logic [AW-1:0] a;
    use_addr_data = 1'b1;
    for (int c = 0; c < 5 * npush + 4; c++) begin
      if (pushed < npush && c >= push_at[pushed]) begin
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b0;
        bif.req_addr  = base + AW'(pushed);
      end else begin
        bif.req_valid = 1'b0;
      end
      rdy = bif.req_ready;
      @(posedge clk);
      if (bif.req_valid && rdy) begin
        chk($sformatf("%s_accept%0d_edge", tag, pushed), c, acc_exp[pushed]);
        pushed++;
      end
      #1;
      if (c == cnt_c) chk($sformatf("%s_count", tag), 32'(dut.u_fifo.count), cnt_exp);
      if (bif.rsp_valid) begin
        a = base + AW'(nrsp);
        chk($sformatf("%s_rsp%0d_data", tag, nrsp), bif.rsp_data, {20'hC0000, a});
        chk($sformatf("%s_rsp%0d_cycle", tag, nrsp), c, 5 * (nrsp + 1));
        nrsp++;
      end
    end
    bif.req_valid = 1'b0;
    chk($sformatf("%s_rsp_total", tag), nrsp, npush);
    chk($sformatf("%s_push_total", tag), pushed, npush);
  endtask

  initial begin
    vec_t v;
    int   got;
    int   nrsp;
    int   pa[5];
    int   ae[5];

    vt[0] = '{we: 1'b0, addr: 12'h012, wdata: 32'h0000_0000, rdata: 32'hA5A5_0001, exp_data: 32'hA5A5_0001};
    vt[1] = '{we: 1'b1, addr: 12'h020, wdata: 32'hDEAD_BEEF, rdata: 32'h1234_5678, exp_data: 32'h0000_0000};
    vt[2] = '{we: 1'b0, addr: 12'hFFF, wdata: 32'h5555_5555, rdata: 32'hFFFF_FFFF, exp_data: 32'hFFFF_FFFF};
    vt[3] = '{we: 1'b1, addr: 12'h000, wdata: 32'h0000_0001, rdata: 32'hCAFE_F00D, exp_data: 32'h0000_0000};
    vt[4] = '{we: 1'b0, addr: 12'h800, wdata: 32'h0000_0000, rdata: 32'h0000_0000, exp_data: 32'h0000_0000};

    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;

    // reset state
    #2 rst = 1'b0;
    step();
    step();
    chk("rst_ale",       bif.ale_en,       0);
    chk("rst_rd_en",     bif.bus_read_en,  0);
    chk("rst_wr_en",     bif.bus_write_en, 0);
    chk("rst_addr",      bif.addr_input,   0);
    chk("rst_wdata",     bif.data_write,   0);
    chk("rst_rsp_valid", bif.rsp_valid,    0);
    chk("rst_rsp_data",  bif.rsp_data,     0);
    chk("rst_rsp_err",   bif.rsp_err,      0);
    chk("rst_busy",      bif.busy,         0);
    chk("rst_req_ready", bif.req_ready,    1);
    rst = 1'b1;
    step();
    step();

    // single transactions: cycle-by-cycle timing from the push edge
    for (int i = 0; i < 5; i++) begin
      v = vt[i];
      use_addr_data = 1'b0;
      rd_val        = v.rdata;
      bif.req_we    = v.we;
      bif.req_addr  = v.addr;
      bif.req_wdata = v.wdata;
      bif.req_valid = 1'b1;
      step();
      bif.req_valid = 1'b0;
      chk($sformatf("v%0d_c0_ale", i),  bif.ale_en, 0);
      chk($sformatf("v%0d_c0_busy", i), bif.busy,   1);
      step();
      chk($sformatf("v%0d_c1_ale", i),  bif.ale_en, 1);
      chk($sformatf("v%0d_c1_en", i),   bif.bus_read_en | bif.bus_write_en, 0);
      chk($sformatf("v%0d_c1_addr", i), bif.addr_input, v.addr);
      step();
      chk($sformatf("v%0d_c2_ale", i),  bif.ale_en, 0);
      chk($sformatf("v%0d_c2_rd", i),   bif.bus_read_en,  !v.we);
      chk($sformatf("v%0d_c2_wr", i),   bif.bus_write_en, v.we);
      if (v.we) chk($sformatf("v%0d_c2_wdata", i), bif.data_write, v.wdata);
      step();
      chk($sformatf("v%0d_c3_en", i),   bif.bus_read_en | bif.bus_write_en, 0);
      chk($sformatf("v%0d_c3_addr", i), bif.addr_input, v.addr);
      step();
      chk($sformatf("v%0d_c4_rsp", i),  bif.rsp_valid, 0);
      if (v.we) chk($sformatf("v%0d_c4_wdata", i), bif.data_write, v.wdata);
      step();
      chk($sformatf("v%0d_c5_rsp", i),  bif.rsp_valid, 1);
      chk($sformatf("v%0d_c5_we", i),   bif.rsp_we,    v.we);
      chk($sformatf("v%0d_c5_data", i), bif.rsp_data,  v.exp_data);
      chk($sformatf("v%0d_c5_err", i),  bif.rsp_err,   0);
      chk($sformatf("v%0d_c5_addr", i), bif.addr_input, 0);
      step();
      chk($sformatf("v%0d_c6_rsp", i),  bif.rsp_valid, 0);
      chk($sformatf("v%0d_c6_busy", i), bif.busy,      0);
      step();
    end

    // five back-to-back pushes into a depth-4 queue
    pa = '{0, 1, 2, 3, 4};
    ae = '{0, 1, 2, 3, 6};
    run_seq("full", 5, pa, ae, 12'h100, 3, 4);
    step();
    step();

    // push coinciding with a completion while two entries are queued
    pa = '{0, 1, 5, 0, 0};
    ae = '{0, 1, 5, 0, 0};
    run_seq("pushpop", 3, pa, ae, 12'h140, 5, 2);
    step();
    step();

    // controller never returns ready: error after 15 WAIT cycles, then next launches
    use_addr_data = 1'b1;
    hang          = 1'b1;
    bif.req_we    = 1'b0;
    bif.req_addr  = 12'h200;
    bif.req_valid = 1'b1;
    step();
    bif.req_addr  = 12'h201;
    step();
    bif.req_valid = 1'b0;
    got = -1;
    for (int c = 2; c < 40 && got < 0; c++) begin
      step();
      if (bif.rsp_valid) begin
        got = c;
        chk("tmo_err",  bif.rsp_err,  1);
        chk("tmo_data", bif.rsp_data, 0);
      end
    end
    chk("tmo_cycle", got, 18);
    hang      = 1'b0;
    release_b = 1'b1;
    step();
    release_b = 1'b0;
    chk("tmo_next_ale",  bif.ale_en,     1);
    chk("tmo_next_addr", bif.addr_input, 12'h201);
    got = -1;
    for (int c = 20; c < 30 && got < 0; c++) begin
      step();
      if (bif.rsp_valid) begin
        got = c;
        chk("tmo_next_err",  bif.rsp_err,  0);
        chk("tmo_next_data", bif.rsp_data, 32'hC000_0201);
      end
    end
    chk("tmo_next_cycle", got, 23);
    step();
    step();

    // reset pulsed during WAIT with two entries queued
    bif.req_addr  = 12'h300;
    bif.req_valid = 1'b1;
    step();
    bif.req_addr  = 12'h301;
    step();
    bif.req_valid = 1'b0;
    step();
    step();
    step();
    chk("rstw_pre_addr", bif.addr_input, 12'h300);
    rst = 1'b0;
    #1;
    chk("rstw_addr",  bif.addr_input, 0);
    chk("rstw_ale",   bif.ale_en | bif.bus_read_en | bif.bus_write_en, 0);
    chk("rstw_busy",  bif.busy,      0);
    chk("rstw_ready", bif.req_ready, 1);
    nrsp = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (bif.rsp_valid) nrsp++;
    end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bif.rsp_valid || bif.ale_en) nrsp++;
    end
    chk("rstw_no_rsp",     nrsp,          0);
    chk("rstw_post_busy",  bif.busy,      0);
    chk("rstw_post_ready", bif.req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sys_bus_master.md
# sys_bus_master

Bus-master sequencer that sits directly upstream of the system bus controller. It buffers read/write requests from a core-side requester in a small FIFO and converts each one into the controller's address-latch / read-or-write / wait-for-ready sequence. It returns read data, or a completion error, on a single-cycle response strobe. One transaction is in flight at a time, with a timeout guarding against a bus that never returns ready.

## Interface
- `ADDR_W`, default `` `BUS_ADDR_WIDTH ``: bus address width (IO select plus in-device offset).
- `DATA_W`, default `` `MEM_WIDTH ``: data word width.
- `FIFO_DEPTH`, default 4: request FIFO entries, power of two, ≥2.
- `TIMEOUT`, default 15: maximum WAIT cycles before an error completion, 1..255.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request offered.
- `req_ready` output 1: equals !fifo_full (combinational); a push occurs when `req_valid & req_ready`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: target address.
- `req_wdata` input DATA_W: write data, ignored for reads.
- `ale_en` output 1: address-latch strobe to the bus controller.
- `bus_read_en` output 1: read command.
- `bus_write_en` output 1: write command.
- `addr_input` output ADDR_W: address to the bus controller.
- `data_write` output DATA_W: write data to the bus controller.
- `data_read` input DATA_W: read data from the bus controller.
- `bus_ready` input 1: controller idle/complete indicator.
- `rsp_valid` output 1: one-cycle completion pulse, no backpressure.
- `rsp_we` output 1: type of the completed request.
- `rsp_data` output DATA_W: read data; 0 for writes and for errors.
- `rsp_err` output 1: completion was a timeout.
- `busy` output 1: FIFO non-empty or state ≠ IDLE.

## Operation
- All bus-side and response outputs are registered.
- Reset values: all outputs 0 except `req_ready` = 1. FIFO is emptied, state = IDLE, timeout counter = 0.
- IDLE: if the FIFO is non-empty and `bus_ready` = 1, load the head entry into the address/data/type registers, assert `ale_en`, and go to ALE.
- ALE: deassert `ale_en`; assert `bus_read_en` or `bus_write_en` per the type; go to CMD.
- CMD: deassert both enables; hold `addr_input` and `data_write`; clear the counter; go to WAIT.
- WAIT: each cycle, increment the counter. Record that `bus_ready` = 0 has been seen. Completion occurs on the first WAIT cycle with `bus_ready` = 1 after low has been seen. On completion:
  - capture `data_read` (reads only);
  - pulse `rsp_valid`;
  - pop the FIFO;
  - go to IDLE.
- Timeout: if the counter reaches `TIMEOUT` without completion, pulse `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0, pop the entry, and go to IDLE.
- `addr_input` and `data_write` are held from ALE through WAIT. They return to 0 in IDLE.
- The FIFO entry is popped only on completion or timeout, never at launch.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged.
- Full FIFO: `req_ready` = 0 and no push occurs. A pop in that cycle makes `req_ready` = 1 on the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- Reset asserted mid-transaction: the transaction is abandoned immediately, no `rsp_valid` is issued, all queued requests are discarded, and the bus strobes drop asynchronously.

## Timing
- A request is pushed at edge 0.
- `ale_en` is high during cycle 1.
- The enable is high during cycle 2.
- `bus_ready` is low during cycle 3.
- With a conforming controller, `bus_ready` is high during cycle 4 and `rsp_valid` is high during cycle 5.
- Read latency is therefore 5 cycles from push to response.
- A queued next request issues `ale_en` in the cycle right after `rsp_valid`. Steady-state throughput is one transaction per 5 cycles.
- `ale_en` and the command enables are each exactly one cycle wide and never overlap.

## Structure
- `def.v` gains the master state encodings: `BM_IDLE`, `BM_ALE`, `BM_CMD`, `BM_WAIT`, 2-bit binary.
- `def.v` also gains the `BM_FIFO_DEPTH` and `BM_TIMEOUT` defaults.
- One sub-module: `bm_req_fifo`, a synchronous FIFO of `{we, addr, wdata}` with full/empty/count outputs and the same asynchronous active-low reset.

## Test plan
- Single read of addr 0x012 with a model controller returning 0xA5A5_0001: `ale_en` in cycle 1, `bus_read_en` in cycle 2, `rsp_valid` in cycle 5 with `rsp_data` = 0xA5A5_0001, `rsp_err` = 0.
- Write of 0xDEAD_BEEF to 0x020: `bus_write_en` in cycle 2 with `data_write` = 0xDEAD_BEEF held through cycle 4. Response has `rsp_we` = 1 and `rsp_data` = 0.
- Push 5 requests back-to-back with depth 4: `req_ready` falls after the 4th push. The 5th is accepted the cycle after the first completion. All 5 responses arrive in order, 5 cycles apart.
- Controller holds `bus_ready` = 0 permanently: `rsp_err` = 1 after 15 WAIT cycles, then the next queued request launches.
- Reset pulsed low during WAIT with 2 entries queued: outputs go to 0 immediately, no `rsp_valid`, `busy` = 0 and `req_ready` = 1 after release.
- Push and completion in the same cycle while the FIFO holds 2 entries: the count stays 2 and the order is preserved.
